// File: rtl/rob_recovery_controller.sv
// Exception recovery sequencer: flushes ROB entries from the faulting pointer up to
// the tail, restores the ROB tail, then redirects fetch, stalling the front end throughout.
module rob_recovery_controller #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recover,
  input  logic [PTR_W-1:0] recover_rob_ptr,
  input  logic [31:0]      trap_pc,
  input  logic [PTR_W-1:0] rob_tail,
  input  logic             rob_full,
  output logic             flush_valid,
  output logic [PTR_W-1:0] flush_idx,
  output logic             tail_restore_valid,
  output logic [PTR_W-1:0] new_tail,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             stall_frontend,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, TAIL, REDIRECT} state_t;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = {1'b1, {PTR_W{1'b0}}};

  state_t           state, state_nx;
  logic             recover_q;
  logic             armed;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cur_q;
  logic [PTR_W-1:0] tail_q;
  logic [31:0]      pc_q;
  logic [31:0]      rpc_q;
  logic [PTR_W:0]   count_q;

  logic             accept;
  logic [PTR_W-1:0] span;
  logic [PTR_W:0]   count_init;

  always_comb begin
    // armed blocks a recover that was already high across reset release from
    // looking like a fresh rising edge; it is set once recover has been seen low.
    accept     = (state == IDLE) && recover && !recover_q && armed;
    span       = rob_tail - recover_rob_ptr;
    count_init = {1'b0, span};
    if (span == '0 && rob_full)
      count_init = CNT_FULL;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = (count_init == '0) ? TAIL : FLUSH;
      FLUSH:    if (count_q == CNT_ONE) state_nx = TAIL;
      TAIL:     state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recover_q <= 1'b0;
      armed     <= 1'b0;
      ptr_q     <= '0;
      cur_q     <= '0;
      tail_q    <= '0;
      pc_q      <= '0;
      rpc_q     <= '0;
      count_q   <= '0;
    end else begin
      recover_q <= recover;
      if (!recover)
        armed <= 1'b1;

      if (accept) begin
        ptr_q   <= recover_rob_ptr;
        pc_q    <= trap_pc;
        count_q <= count_init;
        // Index/tail outputs only move when their strobe is about to assert.
        if (count_init != '0) cur_q  <= recover_rob_ptr;
        else                  tail_q <= recover_rob_ptr;
      end else if (state == FLUSH) begin
        count_q <= count_q - CNT_ONE;
        if (count_q == CNT_ONE) tail_q <= ptr_q;
        else                    cur_q  <= cur_q + PTR_ONE;
      end

      if (state == TAIL)
        rpc_q <= pc_q;
    end
  end

  assign flush_valid        = (state == FLUSH);
  assign flush_idx          = cur_q;
  assign tail_restore_valid = (state == TAIL);
  assign new_tail           = tail_q;
  assign pc_redirect        = (state == REDIRECT);
  assign redirect_pc        = rpc_q;
  assign busy               = (state != IDLE);
  assign stall_frontend     = (state != IDLE);

endmodule
